// File: rtl/delay_measure.sv
`default_nettype none
// ============================================================================
//  Module   : delay_measure
//  Brief    : Round-trip latency meter. Injects a one-cycle marker word into
//             a path under test and counts cycles until it returns.
//  Revision : 1.0 - initial release
// ============================================================================
module delay_measure #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic [DATA_WIDTH-1:0] probe_out,
    output logic                  probe_valid,
    input  logic [DATA_WIDTH-1:0] echo_in,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  delay_cycles
);

    localparam logic [CNT_WIDTH-1:0] c_timeout_cnt = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pat;
    logic [DATA_WIDTH-1:0] w_pat_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_probe_out_nxt;
    logic                  w_probe_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_timeout_nxt;
    logic [CNT_WIDTH-1:0]  w_delay_nxt;
    logic                  w_match;

    assign w_match = (echo_in == r_pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pat        <= '0;
            r_cnt        <= '0;
            probe_out    <= '0;
            probe_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            delay_cycles <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pat        <= w_pat_nxt;
            r_cnt        <= w_cnt_nxt;
            probe_out    <= w_probe_out_nxt;
            probe_valid  <= w_probe_valid_nxt;
            busy         <= w_busy_nxt;
            done         <= w_done_nxt;
            timeout      <= w_timeout_nxt;
            delay_cycles <= w_delay_nxt;
        end
    end

    // Next-state logic also produces the next value of every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_pat_nxt         = r_pat;
        w_cnt_nxt         = r_cnt;
        w_probe_out_nxt   = '0;
        w_probe_valid_nxt = 1'b0;
        w_busy_nxt        = busy;
        w_done_nxt        = 1'b0;
        w_timeout_nxt     = 1'b0;
        w_delay_nxt       = delay_cycles;

        case (r_state)
            ST_IDLE: begin
                // Zero is the idle value on probe_out, so it cannot act as a marker.
                if (start && (pattern != '0)) begin
                    w_state_nxt       = ST_PROBE;
                    w_pat_nxt         = pattern;
                    w_cnt_nxt         = '0;
                    w_busy_nxt        = 1'b1;
                    w_probe_out_nxt   = pattern;
                    w_probe_valid_nxt = 1'b1;
                end
            end

            // The probe cycle itself is offset 0, so a combinational path reads 0.
            ST_PROBE, ST_WAIT: begin
                if (w_match) begin
                    w_state_nxt = ST_REPORT;
                    w_done_nxt  = 1'b1;
                    w_delay_nxt = r_cnt;
                end else if (r_cnt == c_timeout_cnt) begin
                    w_state_nxt   = ST_REPORT;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_delay_nxt   = '1;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end

            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_measure.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_measure
//  Brief    : Self-checking bench for delay_measure with a configurable
//             register delay line, decoy echoes and randomized measurements.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delay_measure;

    localparam int DW       = 32;
    localparam int CW       = 16;
    localparam int TMO      = 16;
    localparam int DL_DEPTH = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] pattern = '0;
    logic [DW-1:0] probe_out;
    logic          probe_valid;
    logic [DW-1:0] echo_in;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] delay_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            path_len  = 0;
    bit            tie_zero  = 1'b0;
    int            decoy_cyc = -1;
    logic [DW-1:0] decoy_val = '0;
    logic [DW-1:0] dl [DL_DEPTH];

    delay_measure #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TMO)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pattern      (pattern),
        .probe_out    (probe_out),
        .probe_valid  (probe_valid),
        .echo_in      (echo_in),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .delay_cycles (delay_cycles)
    );

    always #5 clk = ~clk;

    // Path under test: a register delay line tapped at path_len.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        dl[0] <= probe_out;
        for (int i = 1; i < DL_DEPTH; i++) dl[i] <= dl[i-1];
    end

    always_comb begin
        if (tie_zero)           echo_in = '0;
        else if (path_len == 0) echo_in = probe_out;
        else                    echo_in = dl[path_len-1];
        if (cyc == decoy_cyc)   echo_in = decoy_val;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // len < 0 ties echo to zero; dk >= 0 places a decoy echo dk cycles after the probe.
    task automatic measure(input logic [DW-1:0] pat, input int len, input int dk,
                           input bit dexact, input bit respin);
        int exp_d;
        bit exp_to;
        bit seen;
        exp_d = (len < 0) ? 1 << 30 : len;
        if (dk >= 0 && dexact && dk < exp_d) exp_d = dk;
        exp_to    = (exp_d > TMO);
        tie_zero  = (len < 0);
        path_len  = (len < 0) ? 0 : len;
        decoy_cyc = (dk >= 0) ? cyc + 1 + dk : -1;
        decoy_val = dexact ? pat : (pat ^ 32'h0000_0100);
        start     = 1'b1;
        pattern   = pat;
        @(posedge clk); #1;
        start   = 1'b0;
        pattern = $urandom;
        check("probe_valid", probe_valid, 1);
        check("probe_out", probe_out, pat);
        check("busy_probe", busy, 1);
        seen = 1'b0;
        for (int off = 1; off <= TMO + 4 && !seen; off++) begin
            @(posedge clk); #1;
            if (respin && (off == 2 || off == 3)) begin
                start   = 1'b1;
                pattern = ~pat;
            end else begin
                start = 1'b0;
            end
            check("probe_valid_low", probe_valid, 0);
            if (done) begin
                seen = 1'b1;
                check("done_offset", off, exp_to ? TMO + 1 : exp_d + 1);
                check("delay_cycles", delay_cycles, exp_to ? 16'hFFFF : exp_d);
                check("timeout_flag", timeout, exp_to);
            end else begin
                check("busy_wait", busy, 1);
            end
        end
        start = 1'b0;
        if (!seen) check("done_seen", 0, 1);
        @(posedge clk); #1;
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_timeout", timeout, 0);
        check("post_probe", probe_out, 0);
        check("hold_delay", delay_cycles, exp_to ? 16'hFFFF : exp_d);
        decoy_cyc = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_probe_out"}, probe_out, 0);
        check({tag, "_probe_valid"}, probe_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_delay"}, delay_cycles, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat;
        int len;
        int dk;
        bit dex;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        measure(32'hA5A5_A5A5, 0, -1, 1'b0, 1'b0);
        measure(32'h1234_5678, 5, -1, 1'b0, 1'b0);
        measure(32'hDEAD_BEEF, -1, -1, 1'b0, 1'b0);
        repeat (24) @(posedge clk);
        #1;

        // Start during WAIT is ignored; a start right after done is accepted.
        measure(32'h0F0F_0001, 3, -1, 1'b0, 1'b1);
        measure(32'h7777_0002, 3, -1, 1'b0, 1'b0);

        // Zero pattern must not start a measurement.
        start   = 1'b1;
        pattern = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("zero_pat_busy", busy, 0);
            check("zero_pat_valid", probe_valid, 0);
            check("zero_pat_done", done, 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a measurement.
        tie_zero = 1'b0;
        path_len = 10;
        start    = 1'b1;
        pattern  = 32'hCAFE_0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            check("abort_no_done", done, 0);
        end
        repeat (10) @(posedge clk);
        #1;
        measure(32'hCAFE_0011, 10, -1, 1'b0, 1'b0);

        // Timeout boundary.
        measure(32'h0000_1600, 16, -1, 1'b0, 1'b0);
        measure(32'h0000_1700, 17, -1, 1'b0, 1'b0);
        repeat (24) @(posedge clk);
        #1;

        for (int it = 0; it < 40; it++) begin
            pat = $urandom;
            if (pat == '0) pat = 32'h1;
            len = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
            dk  = -1;
            dex = 1'b0;
            if (len > 0 && $urandom_range(0, 2) == 0) begin
                dk  = $urandom_range(0, len - 1);
                dex = $urandom_range(0, 1) == 1;
            end
            measure(pat, len, dk, dex, 1'b0);
            if (len < 0 || len > TMO || dk >= 0) begin
                repeat (24) @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_measure.md
Name: delay_measure

Overview:
Round-trip latency meter for characterising fixed-latency DSP paths, such as delay lines, filters and FFT stages.
- On request it drives a single-cycle marker word into the path under test and watches the path output for that word.
- It reports the number of clock cycles between injection and return, or flags a timeout.
- It sits beside the path under test in calibration or debug logic; its result feeds alignment of parallel datapaths.

Parameters:
DATA_WIDTH, 32, width of probe and echo words
CNT_WIDTH, 16, width of the cycle counter and of delay_cycles
TIMEOUT, 1024, maximum delay accepted; legal range 1..2^CNT_WIDTH-2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a measurement
pattern  input  DATA_WIDTH  marker word, sampled when start is accepted
probe_out  output  DATA_WIDTH  drives the input of the path under test
probe_valid  output  1  high during the single marker cycle
echo_in  input  DATA_WIDTH  output of the path under test
busy  output  1  measurement in progress
done  output  1  one-cycle pulse when a measurement ends (match or timeout)
timeout  output  1  one-cycle pulse, coincident with done, when no match was found
delay_cycles  output  CNT_WIDTH  measured latency in cycles; held until the next done

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - probe_out=0, probe_valid=0, busy=0, done=0, timeout=0, delay_cycles=0.
  - Counter and latched pattern are cleared.
  - Reset mid-measurement aborts with no done pulse; the first post-reset start behaves normally.
- All outputs are registered.
- States: IDLE, PROBE, WAIT, REPORT.
- IDLE:
  - start=1 with pattern!=0 latches pattern into pat_r, sets busy and moves to PROBE.
  - start with pattern==0 is ignored, because 0 is the idle value on probe_out.
- PROBE (exactly one cycle):
  - probe_out=pat_r, probe_valid=1, cnt=0.
  - echo_in is compared at the closing edge of this cycle, so a combinational path (delay 0) is measured as 0.
- WAIT:
  - probe_out=0, probe_valid=0.
  - Each cycle cnt increments by 1, and echo_in is compared against pat_r at every edge.
- Match rule:
  - Match requires exact equality echo_in==pat_r at the edge where the counter holds D; the result is delay_cycles=D.
  - Only the first match counts; later matches within the same measurement are ignored.
- Timeout rule:
  - Applies at the edge where cnt==TIMEOUT and there is no match.
  - Result is timeout=1 and delay_cycles=all-ones.
  - So delays 0..TIMEOUT are measurable.
  - The counter never wraps.
- REPORT (one cycle):
  - done=1, timeout=1 only on the timeout path, busy=0 at the end of the cycle, then back to IDLE.
- Latency:
  - start accepted at edge n.
  - probe_valid is high in cycle n+1.
  - On a path with delay D, done is high in cycle n+D+2.
- start while busy (PROBE, WAIT or REPORT) is ignored and not queued.
- delay_cycles and timeout status persist after done until the next measurement completes.
- A start in the cycle right after done (IDLE) is accepted.

Test Plan:
- probe_out wired straight to echo_in, pattern=0xA5A5A5A5, start pulse -> probe_valid high 1 cycle; done 2 cycles after start edge with delay_cycles=0, timeout=0.
- echo_in from a 5-stage 32-bit register delay line fed by probe_out, pattern=0x12345678 -> done 7 cycles after start with delay_cycles=5, timeout=0.
- echo_in tied to 0, TIMEOUT=16 -> done and timeout together, delay_cycles=0xFFFF, busy low after the pulse, probe_out back to 0.
- 3-stage delay line; re-assert start during WAIT with a different pattern -> ignored, result delay_cycles=3 with the original pattern; a new start after done measures 3 again.
- start with pattern=0 -> busy stays 0, no probe_valid, no done.
- 10-stage delay line, rst_n pulsed low during WAIT -> all outputs 0 immediately, no done; a subsequent start measures delay_cycles=10.
